// File: rtl/adder_frame_pkg.sv
// Shared types and sizes for the adder frame controller and its serializer.
package adder_frame_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        WAIT_RES = 2'd1,
        SEND     = 2'd2
    } state_t;

    localparam int OPER_BYTES = 8;
    localparam int RES_BYTES  = 5;

endpackage

// File: rtl/adder_frame_ctrl_serializer.sv
// frame_tx_serializer: shifts a loaded result word out MSB byte first over a
// valid/ready handshake; done_o flags the final accepted byte.
module frame_tx_serializer
    import adder_frame_pkg::*;
(
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [8*RES_BYTES-1:0] data_i,
    input  logic                   ready_i,
    output logic [7:0]             byte_o,
    output logic                   valid_o,
    output logic                   done_o
);

    logic [8*RES_BYTES-1:0] sh_q;
    logic [2:0]             idx_q;
    logic                   valid_q;
    logic                   xfer;

    assign xfer = valid_q && ready_i;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sh_q    <= '0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            sh_q    <= data_i;
            idx_q   <= 3'd0;
            valid_q <= 1'b1;
        end else if (xfer) begin
            sh_q <= {sh_q[8*RES_BYTES-9:0], 8'h00};
            if (idx_q == 3'(RES_BYTES - 1)) begin
                idx_q   <= 3'd0;
                valid_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    assign byte_o  = sh_q[8*RES_BYTES-1 -: 8];
    assign valid_o = valid_q;
    assign done_o  = xfer && (idx_q == 3'(RES_BYTES - 1));

endmodule

// File: rtl/adder_frame_ctrl.sv
// Collects an 8-byte operand frame, waits for the adder, returns 5 result bytes.
// Optional partial-frame timeout is built when FRAME_TIMEOUT_EN is defined.
//
// state    | meaning
// COLLECT  | shifting in operand bytes, idle when count is 0
// WAIT_RES | operands stable, waiting RESULT_LATENCY cycles for the adder
// SEND     | serializer emitting carry byte then result bytes
module adder_frame_ctrl
    import adder_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned RESULT_LATENCY = 1
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    output logic [63:0] oper_ab,
    output logic        oper_valid,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    output logic [7:0]  tx_byte,
    output logic        tx_byte_valid,
    input  logic        tx_byte_ready,
    output logic        busy,
    output logic        frame_err
);

    state_t                 state_q;
    logic [2:0]             cnt_q;
    logic [63:0]            oper_q;
    logic                   oper_valid_q;
    logic [3:0]             wait_q;
    logic [8*RES_BYTES-1:0] res_q;
    logic                   start_q;
    logic                   busy_q;
    logic                   frame_err_q;
    logic                   tx_done;
    logic                   tmo_fire;

`ifdef FRAME_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr_q;

    // Reloaded by every strobe; only meaningful while a partial frame is held.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else if (rx_byte_valid) begin
            tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    assign tmo_fire = (state_q == COLLECT) && (cnt_q != 3'd0) && !rx_byte_valid
                      && (tmr_q == '0);
`else
    localparam bit TMO_PARAM_SET = (TIMEOUT_CYCLES != 0);

    assign tmo_fire = 1'b0 & TMO_PARAM_SET;
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            cnt_q        <= 3'd0;
            oper_q       <= '0;
            oper_valid_q <= 1'b0;
            wait_q       <= 4'd0;
            res_q        <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            oper_valid_q <= 1'b0;
            start_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (rx_byte_valid) begin
                        oper_q <= {oper_q[55:0], rx_byte};
                        if (cnt_q == 3'(OPER_BYTES - 1)) begin
                            cnt_q        <= 3'd0;
                            oper_valid_q <= 1'b1;
                            wait_q       <= 4'(RESULT_LATENCY - 1);
                            busy_q       <= 1'b1;
                            state_q      <= WAIT_RES;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end else if (tmo_fire) begin
                        cnt_q       <= 3'd0;
                        frame_err_q <= 1'b1;
                    end
                end
                WAIT_RES: begin
                    frame_err_q <= rx_byte_valid;
                    if (wait_q == 4'd0) begin
                        res_q   <= {7'b0, alu_cout, alu_result};
                        start_q <= 1'b1;
                        state_q <= SEND;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                SEND: begin
                    frame_err_q <= rx_byte_valid;
                    if (tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= COLLECT;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    frame_tx_serializer u_ser (
        .sys_clk (sys_clk),
        .rst     (rst),
        .load_i  (start_q),
        .data_i  (res_q),
        .ready_i (tx_byte_ready),
        .byte_o  (tx_byte),
        .valid_o (tx_byte_valid),
        .done_o  (tx_done)
    );

    assign oper_ab    = oper_q;
    assign oper_valid = oper_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_adder_frame_ctrl.sv
// Directed bench for adder_frame_ctrl; the timeout scenario follows FRAME_TIMEOUT_EN.
module tb_adder_frame_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [63:0] oper_ab;
    logic        oper_valid;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic        tx_byte_ready;
    logic        busy;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;

    adder_frame_ctrl #(
        .TIMEOUT_CYCLES (100),
        .RESULT_LATENCY (1)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .oper_ab       (oper_ab),
        .oper_valid    (oper_valid),
        .alu_result    (alu_result),
        .alu_cout      (alu_cout),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid),
        .tx_byte_ready (tx_byte_ready),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    // External 32-bit adder driven by the packed operands.
    assign {alu_cout, alu_result} = {1'b0, oper_ab[63:32]} + {1'b0, oper_ab[31:0]};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        tick();
        rx_byte_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [63:0] v, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(v[63-8*i -: 8]);
    endtask

    // Entered one cycle after the 8th strobe; checks packing, latency and the 5 tx bytes.
    task automatic finish_frame(input string name, input logic [63:0] v, input logic [39:0] exp_tx,
                                input int stall_idx, input int stall_cycles, input bit inject);
        logic [39:0] got;
        logic [7:0]  held;
        int          n;
        int          stall_left;
        bit          stable_ok;
        got        = '0;
        held       = '0;
        n          = 0;
        stall_left = stall_cycles;
        stable_ok  = 1'b1;
        check({name, " oper_ab"}, oper_ab, v);
        check({name, " oper_valid pulse"}, oper_valid, 1);
        check({name, " busy"}, busy, 1);
        check({name, " tx_valid c1"}, tx_byte_valid, 0);
        tick();
        check({name, " oper_valid drop"}, oper_valid, 0);
        check({name, " tx_valid c2"}, tx_byte_valid, 0);
        tick();
        check({name, " tx_valid c3"}, tx_byte_valid, 1);
        if (inject) begin
            tx_byte_ready = 1'b0;
            send_byte(8'hAA);
            check({name, " frame_err in SEND"}, frame_err, 1);
            check({name, " oper_ab kept"}, oper_ab, v);
        end
        for (int c = 0; c < 200 && n < 5; c++) begin
            if (n == stall_idx && stall_left > 0 && (tx_byte_valid || stall_left < stall_cycles)) begin
                tx_byte_ready = 1'b0;
                if (stall_left == stall_cycles) held = tx_byte;
                else if (!tx_byte_valid || tx_byte != held) stable_ok = 1'b0;
                stall_left--;
            end else begin
                tx_byte_ready = 1'b1;
                if (tx_byte_valid) begin
                    got = {got[31:0], tx_byte};
                    n++;
                end
            end
            tick();
        end
        tx_byte_ready = 1'b1;
        check({name, " tx count"}, n, 5);
        check({name, " tx bytes"}, got, exp_tx);
        if (stall_cycles > 0) check({name, " stall stable"}, stable_ok, 1);
        check({name, " tx_valid drop"}, tx_byte_valid, 0);
        check({name, " busy drop"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] prev;
        bit          seen;
        rst           = 1'b1;
        rx_byte       = 8'h00;
        rx_byte_valid = 1'b0;
        tx_byte_ready = 1'b1;
        repeat (3) tick();
        check("rst oper_ab", oper_ab, 0);
        check("rst oper_valid", oper_valid, 0);
        check("rst tx_byte", tx_byte, 0);
        check("rst tx_valid", tx_byte_valid, 0);
        check("rst busy", busy, 0);
        check("rst frame_err", frame_err, 0);
        rst = 1'b0;
        tick();

        send_bytes(64'h00000005_00000003, 0, 7);
        finish_frame("f1", 64'h00000005_00000003, 40'h00_00000008, -1, 0, 0);

        send_bytes(64'hFFFFFFFF_00000001, 0, 7);
        finish_frame("f2", 64'hFFFFFFFF_00000001, 40'h01_00000000, -1, 0, 0);

        send_bytes(64'h12345678_9ABCDEF0, 0, 7);
        finish_frame("f3", 64'h12345678_9ABCDEF0, 40'h00_ACF13568, 2, 10, 0);

        send_bytes(64'h80000000_80000001, 0, 7);
        finish_frame("f4", 64'h80000000_80000001, 40'h01_00000001, -1, 0, 1);
        check("f4 frame_err clear", frame_err, 0);

        send_bytes(64'hDEADBEEF_CAFEF00D, 0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst oper_ab", oper_ab, 0);
        check("midrst busy", busy, 0);
        send_bytes(64'h0000FFFF_0000FFFF, 0, 7);
        finish_frame("f5", 64'h0000FFFF_0000FFFF, 40'h00_0001FFFE, -1, 0, 0);
        prev = 64'h0000FFFF_0000FFFF;

`ifdef FRAME_TIMEOUT_EN
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        seen = 1'b0;
        repeat (99) begin
            if (frame_err) seen = 1'b1;
            tick();
        end
        check("tmo early err", seen, 0);
        check("tmo err c100", frame_err, 0);
        tick();
        check("tmo err pulse", frame_err, 1);
        check("tmo oper_ab kept", oper_ab, {prev[39:0], 24'hAABBCC});
        tick();
        check("tmo err drop", frame_err, 0);
        send_bytes(64'h11111111_22222222, 0, 7);
        finish_frame("f6", 64'h11111111_22222222, 40'h00_33333333, -1, 0, 0);
`else
        send_bytes(64'h11111111_22222222, 0, 2);
        seen = 1'b0;
        repeat (150) begin
            if (frame_err) seen = 1'b1;
            tick();
        end
        check("partial no err", seen, 0);
        check("partial oper_ab", oper_ab, {prev[39:0], 24'h111111});
        send_bytes(64'h11111111_22222222, 3, 7);
        finish_frame("f6", 64'h11111111_22222222, 40'h00_33333333, -1, 0, 0);
`endif

        send_bytes(64'h00000001_00000001, 0, 7);
        tick();
        tick();
        check("sendrst pre valid", tx_byte_valid, 1);
        tx_byte_ready = 1'b0;
        rst           = 1'b1;
        tick();
        rst = 1'b0;
        check("sendrst tx_valid", tx_byte_valid, 0);
        check("sendrst tx_byte", tx_byte, 0);
        check("sendrst busy", busy, 0);
        tx_byte_ready = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            if (tx_byte_valid) seen = 1'b1;
            tick();
        end
        check("sendrst no tx", seen, 0);

        send_bytes(64'h00000005_00000003, 0, 7);
        finish_frame("f7", 64'h00000005_00000003, 40'h00_00000008, -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_frame_ctrl.md
ADDER_FRAME_CTRL -- requirements
Module: adder_frame_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 1000000, maximum idle cycles allowed between bytes of one operand frame.
REQ-002 Parameter RESULT_LATENCY, 1, number of cycles from the oper_valid pulse to the alu_result sample (range 1..15).
REQ-003 sys_clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rx_byte  in  8  received UART byte.
REQ-006 rx_byte_valid  in  1  one-cycle strobe qualifying rx_byte.
REQ-007 oper_ab  out  64  packed operands: {operand A[63:32], operand B[31:0]}.
REQ-008 oper_valid  out  1  one-cycle pulse when oper_ab is newly complete.
REQ-009 alu_result  in  32  adder result, combinational from oper_ab.
REQ-010 alu_cout  in  1  adder carry-out.
REQ-011 tx_byte  out  8  byte offered to the UART transmitter.
REQ-012 tx_byte_valid  out  1  valid for tx_byte; held until accepted.
REQ-013 tx_byte_ready  in  1  transmitter accept; a transfer occurs when valid and ready are both high.
REQ-014 busy  out  1  high in any state other than COLLECT.
REQ-015 frame_err  out  1  one-cycle pulse on a dropped byte or a timeout abort.

Function
REQ-016 The FSM SHALL have three states: COLLECT -> WAIT_RES -> SEND -> COLLECT.
REQ-017 COLLECT: each rx_byte_valid SHALL shift the byte in MSB-first (oper_ab <= {oper_ab[55:0], rx_byte}) and increment a 3-bit byte count.
REQ-018 When the 8th byte is accepted, the block SHALL pulse oper_valid in the next cycle, clear the count, and enter WAIT_RES.
REQ-019 oper_ab SHALL change only during COLLECT; it is held stable through WAIT_RES and SEND.
REQ-020 WAIT_RES: after RESULT_LATENCY cycles, the block SHALL capture {7'b0, alu_cout, alu_result} into a 40-bit result register and enter SEND.
REQ-021 SEND: the block SHALL emit 5 bytes, most significant first (carry byte, then result[31:24] down to result[7:0]), advancing only on a valid&&ready transfer.
REQ-022 tx_byte and tx_byte_valid SHALL remain stable while ready is low.
REQ-023 After the 5th transfer, the block SHALL drop tx_byte_valid in the next cycle and return to COLLECT.
REQ-024 An rx_byte_valid seen in WAIT_RES or SEND SHALL be discarded with a frame_err pulse; oper_ab is unchanged.
REQ-025 Total latency from the 8th rx strobe to the first tx_byte_valid SHALL be RESULT_LATENCY+2 cycles.

Reset
REQ-026 While rst is high at a clock edge, the block SHALL set: state COLLECT; byte count 0; oper_ab 0; oper_valid 0; tx_byte 0; tx_byte_valid 0; busy 0; frame_err 0; timeout counter 0.
REQ-027 A reset asserted mid-frame or mid-SEND SHALL abort the operation immediately; no partial byte is emitted afterwards.

Configuration
REQ-028 With FRAME_TIMEOUT_EN defined: in COLLECT with a nonzero count, after TIMEOUT_CYCLES cycles without rx_byte_valid, the block SHALL clear the count, pulse frame_err, and leave oper_ab unchanged.
REQ-029 With FRAME_TIMEOUT_EN undefined: no timeout counter exists, a partial frame waits indefinitely, and TIMEOUT_CYCLES is ignored.

Structure
REQ-030 A shared package adder_frame_pkg SHALL hold the state enum (COLLECT, WAIT_RES, SEND), OPER_BYTES=8 and RES_BYTES=5.
REQ-031 The 5-byte output shifter with its valid/ready handshake SHALL be a sub-module named frame_tx_serializer; all other logic stays in adder_frame_ctrl.

Verification
REQ-032 Bytes 00 00 00 05 00 00 00 03 -> oper_ab=64'h00000005_00000003, one oper_valid pulse; with alu_result=8, cout=0, tx bytes are 00 00 00 00 08.
REQ-033 A=FFFFFFFF, B=00000001, adder returns result 0 with cout 1 -> tx bytes 01 00 00 00 00.
REQ-034 tx_byte_ready held low for 10 cycles on byte 2 -> tx_byte stable and valid held throughout; the 5 bytes complete in order.
REQ-035 An rx strobe during SEND -> frame_err pulse, oper_ab unchanged, and the next frame packs correctly.
REQ-036 rst asserted after 4 bytes -> count 0; the next 8 bytes form a clean frame.
REQ-037 With FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=100, 3 bytes then 100 idle cycles -> frame_err pulse; the next 8 bytes produce the correct oper_ab.
